// File: rtl/ahb_decoder_pkg.sv
// Shared encodings for the AHB address decoder / response mux.
package ahb_decoder_pkg;

  localparam int unsigned HTRANS_W   = 2;
  localparam int unsigned MAX_SLAVES = 16;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned OWNER_W    = 5;
  localparam int unsigned CNT_W      = 16;

  typedef logic [HTRANS_W-1:0] htrans_t;

  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_BUSY   = 2'b01;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;
  localparam htrans_t HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase owner: values 0..15 name a slave, two extra codes above that.
  typedef logic [OWNER_W-1:0] owner_t;

  localparam owner_t OWNER_NONE    = 5'd16;
  localparam owner_t OWNER_DEFAULT = 5'd17;

  // Default-slave two-cycle ERROR response states.
  typedef logic [1:0] dslv_state_t;

  localparam dslv_state_t DSLV_IDLE = 2'd0;
  localparam dslv_state_t DSLV_ERR1 = 2'd1;
  localparam dslv_state_t DSLV_ERR2 = 2'd2;

  // NONSEQ and SEQ are the only transfer types that demand a real response.
  function automatic logic is_active(input htrans_t htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR
// and counts how many such responses were started.
module ahb_default_slave
  import ahb_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  output logic             ready_c,
  output logic             resp_c,
  output logic [CNT_W-1:0] err_count
);

  dslv_state_t      state;
  dslv_state_t      state_d;
  logic [CNT_W-1:0] count_d;

  // State and error counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DSLV_IDLE;
      err_count <= '0;
    end else begin
      state     <= state_d;
      err_count <= count_d;
    end
  end

  // Next state and saturating count on each ERR1 entry.
  always_comb begin
    state_d = state;
    count_d = err_count;
    case (state)
      DSLV_IDLE: if (capture) state_d = DSLV_ERR1;
      DSLV_ERR1: state_d = DSLV_ERR2;
      DSLV_ERR2: state_d = capture ? DSLV_ERR1 : DSLV_IDLE;
      default:   state_d = DSLV_IDLE;
    endcase
    if ((state_d == DSLV_ERR1) && (state != DSLV_ERR1) && (err_count != 16'hFFFF)) begin
      count_d = err_count + CNT_W'(1);
    end
  end

  // Response depends only on state so the master-side HREADY has no loop.
  assign ready_c = (state != DSLV_ERR1);
  assign resp_c  = (state == DSLV_ERR1) || (state == DSLV_ERR2);

endmodule

// File: rtl/ahb_verilog_decoder_mux.sv
// AHB-Lite address decoder with data-phase response mux and default slave.
module ahb_verilog_decoder_mux
  import ahb_decoder_pkg::*;
#(
  parameter int unsigned AHB_NUM_SLAVES = 4,
  parameter int unsigned ADDRESSWIDTH   = 32,
  parameter int unsigned DATAWIDTH      = 32,
  parameter logic [AHB_NUM_SLAVES*ADDRESSWIDTH-1:0] SLAVE_START_ADDRESS =
    {32'd3072, 32'd2048, 32'd1024, 32'd0},
  parameter logic [AHB_NUM_SLAVES*ADDRESSWIDTH-1:0] SLAVE_END_ADDRESS =
    {32'd4095, 32'd3071, 32'd2047, 32'd1023}
) (
  input  logic                                HCLK,
  input  logic                                HRESET,
  input  logic [ADDRESSWIDTH-1:0]             HADDR,
  input  logic [1:0]                          HTRANS,
  output logic [AHB_NUM_SLAVES-1:0]           HSEL,
  input  logic [AHB_NUM_SLAVES*DATAWIDTH-1:0] HRDATA_S,
  input  logic [AHB_NUM_SLAVES-1:0]           HREADYOUT_S,
  input  logic [AHB_NUM_SLAVES-1:0]           HRESP_S,
  output logic [DATAWIDTH-1:0]                HRDATA,
  output logic                                HREADY,
  output logic                                HRESP,
  output logic [15:0]                         ERR_COUNT
);

  localparam int unsigned NS = AHB_NUM_SLAVES;
  localparam int unsigned AW = ADDRESSWIDTH;
  localparam int unsigned DW = DATAWIDTH;

  // Elaboration-time sanity checks on the address map.
  if ((NS < 1) || (NS > MAX_SLAVES)) begin : g_bad_count
    $error("AHB_NUM_SLAVES must be within 1..16");
  end

  for (genvar g = 0; g < NS; g++) begin : g_map_chk
    if (SLAVE_START_ADDRESS[g*AW +: AW] > SLAVE_END_ADDRESS[g*AW +: AW]) begin : g_bad_region
      $error("slave region start exceeds its end");
    end
  end

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  owner_t           owner_d;
  owner_t           owner_q;
  logic             capture;
  logic             dslv_ready;
  logic             dslv_resp;

  // Address decode; scanning downward leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((HADDR >= SLAVE_START_ADDRESS[i*AW +: AW]) &&
          (HADDR <= SLAVE_END_ADDRESS[i*AW +: AW])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    HSEL = hit ? (NS'(1) << hit_idx) : '0;
  end

  // Owner of the data phase that the current address phase will start.
  always_comb begin
    owner_d = OWNER_NONE;
    if (hit) begin
      owner_d = OWNER_W'(hit_idx);
    end else if (is_active(HTRANS)) begin
      owner_d = OWNER_DEFAULT;
    end
  end

  assign capture = HREADY && !hit && is_active(HTRANS);

  // Data-phase owner register, advanced only when the bus is ready.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q <= OWNER_NONE;
    end else if (HREADY) begin
      owner_q <= owner_d;
    end
  end

  ahb_default_slave u_default_slave (
    .clk       (HCLK),
    .rst       (HRESET),
    .capture   (capture),
    .ready_c   (dslv_ready),
    .resp_c    (dslv_resp),
    .err_count (ERR_COUNT)
  );

  // Return path mux selected by the registered data-phase owner.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    if (owner_q == OWNER_DEFAULT) begin
      HREADY = dslv_ready;
      HRESP  = dslv_resp;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (owner_q == OWNER_W'(i)) begin
          HRDATA = HRDATA_S[i*DW +: DW];
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_verilog_decoder_mux.sv
// Bench for ahb_verilog_decoder_mux: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_ahb_verilog_decoder_mux;

  logic         clk;
  logic         HRESET;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [3:0]   HSEL;
  logic [127:0] HRDATA_S;
  logic [3:0]   HREADYOUT_S;
  logic [3:0]   HRESP_S;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic         HRESP;
  logic [15:0]  ERR_COUNT;

  int n_cmp  = 0;
  int n_fail = 0;

  ahb_verilog_decoder_mux dut (
    .HCLK        (clk),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .ERR_COUNT   (ERR_COUNT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int unsigned REG_LO [4] = '{0, 1024, 2048, 3072};
  localparam int unsigned REG_HI [4] = '{1023, 2047, 3071, 4095};
  localparam int OWN_NONE = -2;
  localparam int OWN_DEF  = -1;

  // Model state: who owns the data phase and how many error cycles remain.
  int m_owner    = OWN_NONE;
  int m_err_left = 0;
  int m_cnt      = 0;
  bit m_valid    = 1'b0;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if (a >= REG_LO[i] && a <= REG_HI[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic model_ready();
    if (m_owner >= 0) return HREADYOUT_S[m_owner];
    if (m_owner == OWN_DEF) return (m_err_left == 2) ? 1'b0 : 1'b1;
    return 1'b1;
  endfunction

  function automatic logic model_resp();
    if (m_owner >= 0) return HRESP_S[m_owner];
    return (m_owner == OWN_DEF);
  endfunction

  function automatic logic [31:0] model_data();
    if (m_owner >= 0) return HRDATA_S[m_owner*32 +: 32];
    return 32'h0;
  endfunction

  function automatic logic [3:0] model_hsel();
    int d;
    d = decode(HADDR);
    if (d < 0) return 4'h0;
    return 4'(1 << d);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Compare at the falling edge, then advance the model at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("m_hsel",      64'(HSEL),      64'(model_hsel()));
        chk("m_hrdata",    64'(HRDATA),    64'(model_data()));
        chk("m_hready",    64'(HREADY),    64'(model_ready()));
        chk("m_hresp",     64'(HRESP),     64'(model_resp()));
        chk("m_err_count", 64'(ERR_COUNT), 64'(m_cnt));
      end
      @(posedge clk);
      if (HRESET) begin
        m_owner    = OWN_NONE;
        m_err_left = 0;
        m_cnt      = 0;
        m_valid    = 1'b1;
      end else if (m_valid) begin
        logic r;
        int   d;
        r = model_ready();
        if (m_owner == OWN_DEF) m_err_left--;
        if (r) begin
          d = decode(HADDR);
          if (d >= 0) begin
            m_owner = d;
          end else if (HTRANS == 2'd2 || HTRANS == 2'd3) begin
            m_owner    = OWN_DEF;
            m_err_left = 2;
            if (m_cnt < 65535) m_cnt++;
          end else begin
            m_owner = OWN_NONE;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  localparam logic [31:0] EDGE_ADDR [10] = '{0, 1023, 1024, 2047, 2048, 3071,
                                             3072, 4095, 4096, 32'hFFFF_FFFF};

  initial begin
    HRESET      = 1'b1;
    HADDR       = 32'h0;
    HTRANS      = 2'd0;
    HREADYOUT_S = 4'hF;
    HRESP_S     = 4'h0;
    HRDATA_S    = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    tick();
    tick();

    // Reset state, then NONSEQ to slave 1.
    HRESET = 1'b0;
    HADDR  = 32'd1500;
    HTRANS = 2'd2;
    mid();
    chk("rst_hready",    64'(HREADY),    64'h1);
    chk("rst_hresp",     64'(HRESP),     64'h0);
    chk("rst_hrdata",    64'(HRDATA),    64'h0);
    chk("rst_err_count", 64'(ERR_COUNT), 64'h0);
    chk("s1_hsel",       64'(HSEL),      64'h2);
    tick();
    HADDR  = 32'd0;
    HTRANS = 2'd0;
    mid();
    chk("s1_hrdata", 64'(HRDATA), 64'hA1A1_0001);
    chk("s1_hready", 64'(HREADY), 64'h1);

    // Unmapped NONSEQ gets the two-cycle ERROR.
    tick();
    HADDR  = 32'd5000;
    HTRANS = 2'd2;
    mid();
    chk("um_hsel", 64'(HSEL), 64'h0);
    tick();
    HADDR  = 32'd0;
    HTRANS = 2'd0;
    mid();
    chk("err1_hready", 64'(HREADY),    64'h0);
    chk("err1_hresp",  64'(HRESP),     64'h1);
    chk("err1_count",  64'(ERR_COUNT), 64'h1);
    tick();
    mid();
    chk("err2_hready", 64'(HREADY), 64'h1);
    chk("err2_hresp",  64'(HRESP),  64'h1);
    chk("err2_hrdata", 64'(HRDATA), 64'h0);

    // Unmapped IDLE is a zero-wait OKAY.
    tick();
    HADDR  = 32'd5000;
    HTRANS = 2'd0;
    mid();
    chk("idle_hsel", 64'(HSEL), 64'h0);
    tick();
    HADDR = 32'd0;
    mid();
    chk("idle_hready", 64'(HREADY),    64'h1);
    chk("idle_hresp",  64'(HRESP),     64'h0);
    chk("idle_count",  64'(ERR_COUNT), 64'h1);

    // Slave 2 stalls three cycles while the next address targets slave 0.
    tick();
    HADDR       = 32'd2500;
    HTRANS      = 2'd2;
    HREADYOUT_S = 4'b1011;
    tick();
    HADDR = 32'd100;
    mid();
    chk("stall1_hready", 64'(HREADY), 64'h0);
    chk("stall1_hrdata", 64'(HRDATA), 64'hA2A2_0002);
    tick();
    mid();
    chk("stall2_hready", 64'(HREADY), 64'h0);
    tick();
    mid();
    chk("stall3_hready", 64'(HREADY), 64'h0);
    HREADYOUT_S = 4'hF;
    #1;
    chk("stall_release", 64'(HREADY), 64'h1);
    tick();
    HADDR  = 32'd0;
    HTRANS = 2'd0;
    mid();
    chk("s0_owner_hrdata", 64'(HRDATA), 64'hA0A0_0000);

    // Back-to-back unmapped NONSEQ then SEQ after a fresh reset.
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    HADDR  = 32'd5000;
    HTRANS = 2'd2;
    tick();
    HADDR  = 32'd5004;
    HTRANS = 2'd3;
    mid();
    chk("b2b_e1_hready", 64'(HREADY), 64'h0);
    chk("b2b_e1_hresp",  64'(HRESP),  64'h1);
    tick();
    mid();
    chk("b2b_e2_hready", 64'(HREADY), 64'h1);
    chk("b2b_e2_hresp",  64'(HRESP),  64'h1);
    tick();
    HADDR  = 32'd0;
    HTRANS = 2'd0;
    mid();
    chk("b2b_e3_hready", 64'(HREADY), 64'h0);
    chk("b2b_e3_hresp",  64'(HRESP),  64'h1);
    tick();
    mid();
    chk("b2b_e4_hready", 64'(HREADY),    64'h1);
    chk("b2b_e4_hresp",  64'(HRESP),     64'h1);
    chk("b2b_count",     64'(ERR_COUNT), 64'h2);

    // Reset in the middle of ERR1 aborts the error response.
    tick();
    HADDR  = 32'd5000;
    HTRANS = 2'd2;
    tick();
    HADDR  = 32'd0;
    HTRANS = 2'd0;
    mid();
    chk("abort_pre_hready", 64'(HREADY), 64'h0);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    mid();
    chk("abort_hready", 64'(HREADY),    64'h1);
    chk("abort_hresp",  64'(HRESP),     64'h0);
    chk("abort_count",  64'(ERR_COUNT), 64'h0);

    // Random traffic, checked cycle by cycle against the model.
    repeat (3000) begin
      tick();
      HRESET = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: HADDR = 32'($urandom_range(0, 4095));
        1: begin
          logic [31:0] e [10];
          e     = EDGE_ADDR;
          HADDR = e[$urandom_range(0, 9)];
        end
        2: HADDR = $urandom;
        default: HADDR = 32'($urandom_range(4096, 8191));
      endcase
      HTRANS = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) HREADYOUT_S[i] = ($urandom_range(0, 3) != 0);
      HRESP_S  = 4'($urandom);
      HRDATA_S = {$urandom, $urandom, $urandom, $urandom};
    end
    tick();
    mid();
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_verilog_decoder_mux.md
AHB_VERILOG_DECODER_MUX -- requirements
Module: ahb_verilog_decoder_mux

Interface
REQ-001 SHALL have parameter AHB_NUM_SLAVES, default 4, number of slave regions (1..16).
REQ-002 SHALL have parameter ADDRESSWIDTH, default 32, HADDR width.
REQ-003 SHALL have parameter DATAWIDTH, default 32, HRDATA width.
REQ-004 SHALL have parameter SLAVE_START_ADDRESS, default {3072,2048,1024,0}, packed AHB_NUM_SLAVES*ADDRESSWIDTH region starts, slave 0 in LSBs.
REQ-005 SHALL have parameter SLAVE_END_ADDRESS, default {4095,3071,2047,1023}, packed inclusive region ends, same layout.
REQ-006 SHALL have port HCLK, input, 1, sole clock, all state on rising edge.
REQ-007 SHALL have port HRESET, input, 1, synchronous active-high reset.
REQ-008 SHALL have port HADDR, input, ADDRESSWIDTH, master address-phase address.
REQ-009 SHALL have port HTRANS, input, 2, master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-010 SHALL have port HSEL, output, AHB_NUM_SLAVES, one-hot address-phase slave select.
REQ-011 SHALL have port HRDATA_S, input, AHB_NUM_SLAVES*DATAWIDTH, packed slave read data.
REQ-012 SHALL have port HREADYOUT_S, input, AHB_NUM_SLAVES, slave ready outputs.
REQ-013 SHALL have port HRESP_S, input, AHB_NUM_SLAVES, slave responses (0 OKAY, 1 ERROR).
REQ-014 SHALL have port HRDATA, output, DATAWIDTH, muxed read data to master.
REQ-015 SHALL have port HREADY, output, 1, muxed ready to master and all slaves.
REQ-016 SHALL have port HRESP, output, 1, muxed response to master.
REQ-017 SHALL have port ERR_COUNT, output, 16, count of default-slave ERROR responses.

Function
REQ-018 SHALL drive HSEL combinationally from HADDR: bit i high when START_i <= HADDR <= END_i; on overlap only lowest index high; all-zero when unmapped.
REQ-019 SHALL, on HCLK edge with HREADY=1, register data-phase owner: mapped slave index, DEFAULT if unmapped and HTRANS is NONSEQ/SEQ, else NONE; HREADY=0 holds owner.
REQ-020 SHALL, with owner slave i, drive HRDATA/HREADY/HRESP from slice i of HRDATA_S/HREADYOUT_S/HRESP_S (zero added latency).
REQ-021 SHALL, with owner NONE, drive HREADY=1, HRESP=0, HRDATA=0.
REQ-022 SHALL implement default-slave FSM IDLE->ERR1->ERR2: IDLE->ERR1 when DEFAULT captured; ERR1 drives HREADY=0,HRESP=1; ERR2 drives HREADY=1,HRESP=1; ERR2->ERR1 if new DEFAULT captured, else IDLE.
REQ-023 SHALL give IDLE/BUSY to unmapped addresses a zero-wait OKAY (owner NONE).
REQ-024 SHALL increment ERR_COUNT by 1 on each ERR1 entry, saturating at 16'hFFFF.
REQ-025 SHALL drive HRDATA=0 in ERR1/ERR2.

Reset
REQ-026 SHALL, with HRESET=1 at a HCLK edge, set owner=NONE, FSM=IDLE, ERR_COUNT=0, giving HREADY=1, HRESP=0, HRDATA=0 next cycle.
REQ-027 SHALL abort any ERR1/ERR2 or stalled slave data phase on reset without completing it.
REQ-028 SHALL keep HSEL combinational and reset-independent.

Structure
REQ-029 SHALL take HTRANS/HRESP encodings, owner encoding and FSM state type from shared package ahb_decoder_pkg.
REQ-030 SHALL place the default-slave FSM and ERR_COUNT in sub-module ahb_default_slave.
REQ-031 SHALL reject at elaboration AHB_NUM_SLAVES outside 1..16 or any START_i > END_i.

Verification
REQ-032 SHALL test: reset then NONSEQ HADDR=1500 -> HSEL=4'b0010; next cycle HRDATA=HRDATA_S slice 1, HREADY=HREADYOUT_S[1].
REQ-033 SHALL test: NONSEQ HADDR=5000 -> HSEL=0; next cycle HREADY=0,HRESP=1; then HREADY=1,HRESP=1; ERR_COUNT=1.
REQ-034 SHALL test: IDLE HADDR=5000 -> HSEL=0; next cycle HREADY=1,HRESP=0; ERR_COUNT unchanged.
REQ-035 SHALL test: slave 2 holds HREADYOUT_S[2]=0 for 3 cycles while HADDR=100 -> owner stays 2; HREADY=0 three cycles; slave 0 owns after.
REQ-036 SHALL test: back-to-back NONSEQ 5000, SEQ 5004 -> ERR1,ERR2,ERR1,ERR2; ERR_COUNT=2.
REQ-037 SHALL test: HRESET=1 during ERR1 -> next cycle HREADY=1, HRESP=0, ERR_COUNT=0.
